// File: rtl/mat_mul_pkg.sv
// Shared types and helpers for the mat_mul sequencer, its datapath and benches.
package mat_mul_pkg;
    localparam int N_DEF     = 8;
    localparam int W_IN_DEF  = 8;
    localparam int W_OUT_DEF = 32;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FIRE, WAIT, DRAIN} state_t;

    typedef logic signed [N_DEF-1:0][W_IN_DEF-1:0]  operand_row_t;
    typedef logic signed [N_DEF-1:0][W_OUT_DEF-1:0] result_row_t;

    // Cycles from the mat_mul job strobe to its result strobe.
    function automatic int latency(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/mat_mul_ctrl_row_buf.sv
// N x N operand register file, written one row at a time by index.
module mat_row_buf #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [$clog2(N)-1:0]          idx,
    input  logic [N-1:0][W-1:0]           row,
    output logic [N-1:0][N-1:0][W-1:0]    mat
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mat <= '0;
        else if (we)
            mat[idx] <= row;
    end
endmodule

// File: rtl/mat_mul_ctrl.sv
// Loads A and B row by row, fires one mat_mul job, then streams the product
// back one row per beat. A watchdog raises a sticky err if no result arrives.
module mat_mul_ctrl
    import mat_mul_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int N     = 8,
    parameter int WDOG  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N-1:0][W_IN-1:0]            in_row,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N-1:0][W_OUT-1:0]           out_row,
    output logic                              out_last,
    output logic                              busy,
    output logic                              err,
    output logic                              mm_cen,
    output logic                              mm_valid_in,
    output logic [N-1:0][N-1:0][W_IN-1:0]     mm_matrix_1,
    output logic [N-1:0][N-1:0][W_IN-1:0]     mm_matrix_2,
    input  logic                              mm_valid_out,
    input  logic [N-1:0][N-1:0][W_OUT-1:0]    mm_result
);
    localparam int LAT = latency(N);
    localparam int CW  = $clog2(N);
    localparam int WDW = $clog2(LAT + WDOG + 1);

    state_t                         state, state_nx;
    logic [CW-1:0]                  row_cnt, out_cnt;
    logic [WDW-1:0]                 wd_cnt;
    logic [N-1:0][N-1:0][W_OUT-1:0] res;
    logic                           live;
    logic                           in_fire, out_fire, last_row, last_out, wd_hit;

    // live holds in_ready low while reset is applied and until the first edge after it.
    assign in_ready  = live && (state == IDLE || state == LOAD_A || state == LOAD_B);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign mm_cen    = (state == FIRE || state == WAIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_row  = (row_cnt == CW'(N - 1));
    assign last_out  = (out_cnt == CW'(N - 1));
    assign wd_hit    = (wd_cnt == WDW'(LAT + WDOG - 1));
    assign out_row   = res[out_cnt];
    assign out_last  = out_valid && last_out;

    mat_row_buf #(.N(N), .W(W_IN)) u_buf_a (
        .clk(clk), .rst(rst), .we(in_fire && (state == IDLE || state == LOAD_A)),
        .idx(row_cnt), .row(in_row), .mat(mm_matrix_1)
    );

    mat_row_buf #(.N(N), .W(W_IN)) u_buf_b (
        .clk(clk), .rst(rst), .we(in_fire && state == LOAD_B),
        .idx(row_cnt), .row(in_row), .mat(mm_matrix_2)
    );

    always_comb begin
        state_nx    = state;
        mm_valid_in = 1'b0;
        case (state)
            IDLE:    if (in_fire) state_nx = LOAD_A;
            LOAD_A:  if (in_fire && last_row) state_nx = LOAD_B;
            LOAD_B:  if (in_fire && last_row) state_nx = FIRE;
            FIRE: begin
                mm_valid_in = 1'b1;
                state_nx    = WAIT;
            end
            WAIT: begin
                if (mm_valid_out)
                    state_nx = DRAIN;
                else if (wd_hit)
                    state_nx = IDLE;
            end
            DRAIN:   if (out_fire && last_out) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            live    <= 1'b0;
            row_cnt <= '0;
            out_cnt <= '0;
            wd_cnt  <= '0;
            err     <= 1'b0;
            res     <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            // N is a power of two, so the row counter wraps to 0 between A and B.
            if (in_fire)
                row_cnt <= row_cnt + 1'b1;
            if (out_fire)
                out_cnt <= out_cnt + 1'b1;
            if (state == FIRE)
                wd_cnt <= '0;
            else if (state == WAIT && !mm_valid_out)
                wd_cnt <= wd_cnt + 1'b1;
            if (state == WAIT && !mm_valid_out && wd_hit)
                err <= 1'b1;
            if (state == WAIT && mm_valid_out)
                res <= mm_result;
        end
    end
endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Bench for mat_mul_ctrl: behavioural mat_mul stub, table vectors, directed
// corner sequences and randomized back-to-back jobs against a reference product.
module tb_mat_mul_ctrl;
    import mat_mul_pkg::*;

    localparam int N     = 8;
    localparam int W_IN  = 8;
    localparam int W_OUT = 32;
    localparam int WDOG  = 4;
    localparam int L     = latency(N);
    localparam int MIN_PERIOD = 2*N + 1 + L + N + 1;

    typedef logic [N-1:0][W_IN-1:0]         orow_t;
    typedef logic [N-1:0][W_OUT-1:0]        rrow_t;
    typedef logic [N-1:0][N-1:0][W_IN-1:0]  omat_t;
    typedef logic [N-1:0][N-1:0][W_OUT-1:0] rmat_t;
    typedef struct { int a_v; int b_v; int exp_v; } vec_t;

    logic  clk, rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic  busy, err, mm_cen, mm_valid_in, mm_valid_out;
    orow_t in_row;
    rrow_t out_row;
    omat_t mm_matrix_1, mm_matrix_2;
    rmat_t mm_result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int a_m[N][N];
    int b_m[N][N];
    bit stub_dead = 0;
    bit spur = 0;
    logic [L:1] vp = '0;
    rmat_t prod = '0;

    mat_mul_ctrl #(.W_IN(W_IN), .W_OUT(W_OUT), .N(N), .WDOG(WDOG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
        .busy(busy), .err(err), .mm_cen(mm_cen), .mm_valid_in(mm_valid_in),
        .mm_matrix_1(mm_matrix_1), .mm_matrix_2(mm_matrix_2),
        .mm_valid_out(mm_valid_out), .mm_result(mm_result)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    function automatic rmat_t mul(input omat_t m1, input omat_t m2);
        rmat_t r;
        int s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++)
                    s += int'($signed(m1[i][k])) * int'($signed(m2[k][j]));
                r[i][j] = s;
            end
        return r;
    endfunction

    // Datapath stand-in: product appears L cycles after the job strobe.
    always @(posedge clk or posedge rst) begin
        if (rst)
            vp <= '0;
        else begin
            vp <= {vp[L-1:1], mm_valid_in & ~stub_dead};
            if (mm_valid_in)
                prod <= mul(mm_matrix_1, mm_matrix_2);
        end
    end
    assign mm_valid_out = vp[L] | spur;
    assign mm_result    = spur ? {(N*N){32'hdead_beef}} : prod;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_row(input string nm, input rrow_t act, input rrow_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic reset_now(input string tag);
        rst = 1; in_valid = 0; out_ready = 0;
        #1;
        chk({tag, "_in_ready"},  in_ready, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"},  out_last, 0);
        chk({tag, "_err"},       err, 0);
        chk({tag, "_mm_cen"},    mm_cen, 0);
        chk({tag, "_mm_vin"},    mm_valid_in, 0);
        chk({tag, "_a_clr"},     mm_matrix_1 == '0, 1);
        chk({tag, "_row_clr"},   out_row == '0, 1);
        tick(); tick();
        rst = 0;
        tick();
        chk({tag, "_ready_after"}, in_ready, 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = int'($urandom_range(0, 255)) - 128;
                b_m[i][j] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = av;
                b_m[i][j] = bv;
            end
    endtask

    task automatic run_job(input bit gaps, input bit bp, input bit dead, input bit use_fix,
                           input int fix_v, input int abort_row, input int abort_beat,
                           output int t_first, output int t_last);
        int    exp_c[N][N];
        rrow_t er;
        orow_t r;
        int    row, beat, lim, fires, fire_cyc, bad_rdy, early;
        bit    err0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_c[i][j] = use_fix ? fix_v : 0;
                if (!use_fix)
                    for (int k = 0; k < N; k++)
                        exp_c[i][j] += a_m[i][k] * b_m[k][j];
            end
        stub_dead = dead;
        t_first = -1; t_last = -1; row = 0; lim = 0;

        while (row < 2*N && lim < 400) begin
            if (row == abort_row) begin
                reset_now("rst_load");
                return;
            end
            for (int j = 0; j < N; j++)
                if (row < N) r[j] = W_IN'(a_m[row][j]);
                else         r[j] = W_IN'(b_m[row-N][j]);
            in_row   = r;
            in_valid = gaps ? (cyc % 4 == 0) : 1'b1;
            if (in_valid && in_ready) begin
                if (row == 0) t_first = cyc;
                row++;
            end
            tick(); lim++;
        end
        in_valid = 0;
        chk("load_rows", row, 2*N);

        fires = 0; fire_cyc = -1; bad_rdy = 0; early = 0; lim = 0; err0 = err;
        while (lim < 100) begin
            if (dead ? !busy : out_valid) break;
            if (mm_valid_in) begin fires++; fire_cyc = cyc; end
            if (in_ready || !mm_cen || out_valid) bad_rdy++;
            if (!err0 && err) early++;
            tick(); lim++;
        end
        chk("wait_bound", lim < 100, 1);

        if (dead) begin
            // err rises L+WDOG clocks after the FIRE cycle completes.
            chk("wd_err",      err, 1);
            chk("wd_delay",    cyc - fire_cyc, L + WDOG + 1);
            chk("wd_early",    early, 0);
            chk("wd_fires",    fires, 1);
            chk("wd_no_out",   out_valid, 0);
            chk("wd_ready_lo", bad_rdy, 0);
            stub_dead = 0;
            return;
        end

        beat = 0; lim = 0;
        while (beat < N && lim < 400) begin
            if (beat == abort_beat) begin
                reset_now("rst_drain");
                return;
            end
            out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            for (int j = 0; j < N; j++)
                er[j] = W_OUT'(exp_c[beat][j]);
            chk_row("out_row", out_row, er);
            chk("out_valid", out_valid, 1);
            chk("out_last", out_last, beat == N-1);
            if (in_ready || mm_valid_in) bad_rdy++;
            if (out_valid && out_ready) begin
                t_last = cyc;
                beat++;
            end
            tick(); lim++;
        end
        out_ready = 0;
        chk("drain_beats", beat, N);
        chk("fires_once",  fires, 1);
        chk("ready_low",   bad_rdy, 0);
        chk("idle_after",  busy, 0);
        chk("no_extra",    out_valid, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   tf, tl, ptf, ptl;
        vecs[0] = '{-128, -128,  131072};
        vecs[1] = '{-128,  127, -130048};
        vecs[2] = '{ 127,  127,  129032};
        vecs[3] = '{   1,    1,       8};
        vecs[4] = '{  -1,    1,      -8};
        vecs[5] = '{   0,    5,       0};
        vecs[6] = '{ 127, -128, -130048};

        void'($urandom(56));
        rst = 1; in_valid = 0; in_row = '0; out_ready = 0;
        tick(); tick();
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last",  out_last, 0);
        chk("rst_err",       err, 0);
        chk("rst_mm_cen",    mm_cen, 0);
        chk("rst_mm_vin",    mm_valid_in, 0);
        rst = 0;
        tick();
        chk("ready_post_reset", in_ready, 1);

        for (int v = 0; v < 7; v++) begin
            fill_const(vecs[v].a_v, vecs[v].b_v);
            run_job(0, 0, 0, 1, vecs[v].exp_v, -1, -1, tf, tl);
        end

        // Identity A: product rows must equal B rows bit-exactly.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = (i == j) ? 1 : 0;
                b_m[i][j] = i*N + j - 64;
            end
        run_job(0, 0, 0, 0, 0, -1, -1, tf, tl);

        fill_rand();
        run_job(1, 1, 0, 0, 0, -1, -1, tf, tl);

        // Stray result strobe while idle must be ignored.
        spur = 1;
        tick();
        chk("spur_no_out", out_valid, 0);
        chk("spur_idle",   busy, 0);
        spur = 0;
        tick();
        fill_rand();
        run_job(0, 0, 0, 0, 0, -1, -1, tf, tl);

        fill_rand();
        run_job(0, 0, 1, 0, 0, -1, -1, tf, tl);
        fill_rand();
        run_job(0, 1, 0, 0, 0, -1, -1, tf, tl);
        chk("err_sticky", err, 1);

        fill_rand();
        run_job(0, 0, 0, 0, 0, 6, -1, tf, tl);
        fill_rand();
        run_job(0, 0, 0, 0, 0, -1, -1, tf, tl);
        fill_rand();
        run_job(0, 0, 0, 0, 0, -1, 3, tf, tl);
        fill_rand();
        run_job(0, 0, 0, 0, 0, -1, -1, tf, tl);

        // Back-to-back: the IDLE cycle closing one job carries the next job's first row.
        ptf = 0; ptl = 0;
        for (int jb = 0; jb < 10; jb++) begin
            fill_rand();
            run_job(0, 0, 0, 0, 0, -1, -1, tf, tl);
            if (jb > 0) begin
                chk("job_period", tf - ptf, MIN_PERIOD - 1);
                chk("b2b_accept", tf - ptl, 1);
            end
            ptf = tf; ptl = tl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
